// File: rtl/tm1638_frame_engine.sv
// rtl/tm1638_frame_engine.sv - free-running TM1638 refresh engine with key debounce
//
// Each frame reads the four key-scan bytes, writes every segment and LED byte in
// auto-increment mode, then sends a display-control command. One serial bit takes
// two clk_400KHz cycles: phase A (tm_clk=0, DIO updated), phase B (tm_clk=1,
// read bits sampled at its end).
//
// Ports:
//   clk_400KHz  system and serial-bit clock
//   rst         asynchronous active-low reset
//   enable      start a new frame when high in IDLE (or at the end of GAP)
//   seg_data    segment byte per digit, digit i = [8i+7:8i]
//   led_data    LED i on when bit i is set
//   brightness  pulse-width setting 0..7
//   display_on  display enable bit of the control command
//   tm_clk      TM1638 CLK
//   STB         TM1638 strobe, active-low
//   DIO         TM1638 bidirectional data, LSB first
//   key_state   debounced keys
//   key_change  one-cycle pulse when key_state takes a new value
//   frame_done  one-cycle pulse after the control command
//   busy        high from frame start until the end of GAP

module tm1638_frame_engine #(
  parameter int NUM_DIGITS      = 8,
  parameter int GAP_CYCLES      = 16,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                    clk_400KHz,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   led_data,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  output logic                    tm_clk,
  output logic                    STB,
  inout  wire                     DIO,
  output logic [7:0]              key_state,
  output logic                    key_change,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int              ADDR_BYTES = 1 + 2 * NUM_DIGITS;
  localparam int              DBW        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [15:0]     ADDR_TX    = 16'(16 * ADDR_BYTES);
  localparam logic [15:0]     GAP_LEN    = 16'(GAP_CYCLES);
  localparam logic [DBW-1:0]  DB_MAX     = DBW'(DEBOUNCE_FRAMES);

  typedef enum logic [2:0] {
    IDLE, KEY_CMD, TURN, KEY_RD, DATA_CMD, ADDR_DATA, CTRL_CMD, GAP
  } state_t;

  state_t state, state_n;

  // cnt counts cycles inside the current state; a state is its transfer
  // window (tx_len cycles) followed by the separator, if any.
  logic [15:0] cnt, state_len, tx_len;
  logic        in_tx, last;
  logic [11:0] byte_idx;
  logic [7:0]  tx_byte;
  logic        dio_oe, dio_o;

  logic [8*NUM_DIGITS-1:0] seg_q;
  logic [NUM_DIGITS-1:0]   led_q;
  logic [2:0]              bri_q;
  logic                    on_q;

  logic [31:0]    raw;
  logic [7:0]     raw_keys, prev_keys;
  logic [DBW-1:0] db_cnt, db_next;

  assign DIO      = dio_oe ? dio_o : 1'bz;
  assign in_tx    = cnt < tx_len;
  assign last     = cnt == state_len - 16'd1;
  assign byte_idx = cnt[15:4];

  always_comb begin
    state_len = 16'd1;
    tx_len    = 16'd0;
    case (state)
      KEY_CMD:   begin state_len = 16'd16;        tx_len = 16'd16;  end
      TURN:      begin state_len = 16'd2;                           end
      KEY_RD:    begin state_len = 16'd66;        tx_len = 16'd64;  end
      DATA_CMD:  begin state_len = 16'd18;        tx_len = 16'd16;  end
      ADDR_DATA: begin state_len = ADDR_TX + 16'd2; tx_len = ADDR_TX; end
      CTRL_CMD:  begin state_len = 16'd18;        tx_len = 16'd16;  end
      GAP:       begin state_len = GAP_LEN;                         end
      default:   ;
    endcase
  end

  // Byte on the wire: ADDR_DATA interleaves segment and LED bytes after 0xC0.
  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      KEY_CMD:  tx_byte = 8'h42;
      DATA_CMD: tx_byte = 8'h40;
      CTRL_CMD: tx_byte = {4'b1000, on_q, bri_q};
      ADDR_DATA: begin
        if (byte_idx == 12'd0) tx_byte = 8'hC0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (byte_idx == 12'(2 * i + 1)) tx_byte = seg_q[8*i +: 8];
          if (byte_idx == 12'(2 * i + 2)) tx_byte = {7'b0, led_q[i]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    STB        = 1'b1;
    tm_clk     = 1'b1;
    dio_oe     = 1'b1;
    dio_o      = 1'b1;
    frame_done = 1'b0;
    busy       = state != IDLE;
    case (state)
      IDLE: if (enable) state_n = KEY_CMD;
      TURN: begin
        STB    = 1'b0;
        dio_oe = 1'b0;
        if (last) state_n = KEY_RD;
      end
      KEY_RD: begin
        if (in_tx) begin
          STB    = 1'b0;
          tm_clk = cnt[0];
          dio_oe = 1'b0;
        end
        if (last) state_n = DATA_CMD;
      end
      GAP: if (last) state_n = enable ? KEY_CMD : IDLE;
      default: begin
        if (in_tx) begin
          STB    = 1'b0;
          tm_clk = cnt[0];
          dio_o  = tx_byte[cnt[3:1]];
        end
        if (state == CTRL_CMD && cnt == 16'd16) frame_done = 1'b1;
        if (last) begin
          case (state)
            KEY_CMD:   state_n = TURN;
            DATA_CMD:  state_n = ADDR_DATA;
            ADDR_DATA: state_n = CTRL_CMD;
            CTRL_CMD:  state_n = GAP;
            default:   state_n = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_400KHz or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == IDLE) ? 16'd0 : cnt + 16'd1;
    end
  end

  // Key byte b contributes bit0 and bit4 as keys 2b and 2b+1.
  always_comb begin
    raw_keys = 8'd0;
    for (int b = 0; b < 4; b++) begin
      raw_keys[2*b]   = raw[8*b];
      raw_keys[2*b+1] = raw[8*b+4];
    end
  end

  always_comb begin
    if (raw_keys == prev_keys) db_next = (db_cnt == DB_MAX) ? DB_MAX : db_cnt + 1'b1;
    else                       db_next = DBW'(1);
  end

  always_ff @(posedge clk_400KHz or negedge rst) begin
    if (!rst) begin
      seg_q      <= '0;
      led_q      <= '0;
      bri_q      <= 3'd0;
      on_q       <= 1'b0;
      raw        <= 32'd0;
      prev_keys  <= 8'd0;
      db_cnt     <= '0;
      key_state  <= 8'd0;
      key_change <= 1'b0;
    end else begin
      key_change <= 1'b0;
      if (state_n == KEY_CMD && state != KEY_CMD) begin
        seg_q <= seg_data;
        led_q <= led_data;
        bri_q <= brightness;
        on_q  <= display_on;
      end
      // Sample at the end of phase B, shifting right so the first bit lands in raw[0].
      if (state == KEY_RD && in_tx && cnt[0]) raw <= {DIO, raw[31:1]};
      if (state == KEY_RD && cnt == 16'd64) begin
        prev_keys <= raw_keys;
        db_cnt    <= db_next;
        if (db_next == DB_MAX && raw_keys != key_state) begin
          key_state  <= raw_keys;
          key_change <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_frame_engine.sv
// tb/tb_tm1638_frame_engine.sv - scoreboard bench for tm1638_frame_engine
module tb_tm1638_frame_engine;

  logic        clk_400KHz = 1'b0;
  logic        rst, enable, enable_s;
  logic [63:0] seg_data;
  logic [7:0]  led_data;
  logic [2:0]  brightness;
  logic        display_on;
  logic        tm_clk, STB, key_change, frame_done, busy;
  logic [7:0]  key_state;
  wire         DIO;
  logic        tm_clk_s, stb_s, key_change_s, frame_done_s, busy_s;
  logic [7:0]  key_state_s;
  wire         dio_s;

  logic tb_drive = 1'b0;
  logic tb_bit   = 1'b1;
  assign DIO = (tb_drive && !STB) ? tb_bit : 1'bz;

  always #5 clk_400KHz = ~clk_400KHz;

  tm1638_frame_engine u_dut (
    .clk_400KHz(clk_400KHz), .rst(rst), .enable(enable),
    .seg_data(seg_data), .led_data(led_data), .brightness(brightness),
    .display_on(display_on), .tm_clk(tm_clk), .STB(STB), .DIO(DIO),
    .key_state(key_state), .key_change(key_change),
    .frame_done(frame_done), .busy(busy)
  );

  tm1638_frame_engine #(.NUM_DIGITS(4), .GAP_CYCLES(2), .DEBOUNCE_FRAMES(3)) u_small (
    .clk_400KHz(clk_400KHz), .rst(rst), .enable(enable_s),
    .seg_data(seg_data[31:0]), .led_data(led_data[3:0]), .brightness(brightness),
    .display_on(display_on), .tm_clk(tm_clk_s), .STB(stb_s), .DIO(dio_s),
    .key_state(key_state_s), .key_change(key_change_s),
    .frame_done(frame_done_s), .busy(busy_s)
  );

  typedef struct {
    logic [7:0] b;
    bit         last;
    bit         eof;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] kq[$];
  exp_t       last_e;
  int         checks = 0;
  int         errors = 0;

  logic [63:0] seg_e;
  logic [7:0]  led_e;
  logic [2:0]  bri_e;
  logic        on_e;
  logic [7:0]  key_bytes[4];

  bit         pending = 1'b1;
  logic       prev_stb = 1'b1;
  logic       prev_tclk = 1'b1;
  int         bit_cnt, byte_in_txn, rd_fall, rd_rise;
  int         key_reads = 0;
  int         kc_count = 0;
  bit         is_key;
  logic [7:0] cur_byte, cur_first, last_ctrl;
  logic [7:0] addr_obs[16];
  logic [31:0] drv_raw;
  logic [7:0] m_prev, m_state, r8, kexp;
  int         m_cnt;

  // Inputs change only at posedge+1, so this is what the DUT sees at each edge.
  always @(posedge clk_400KHz) begin
    seg_e = seg_data;
    led_e = led_data;
    bri_e = brightness;
    on_e  = display_on;
  end

  function automatic void push_frame();
    exp_q.push_back('{8'h42, 1'b1, 1'b0});
    exp_q.push_back('{8'h40, 1'b1, 1'b0});
    exp_q.push_back('{8'hC0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{seg_e[8*i +: 8], 1'b0, 1'b0});
      exp_q.push_back('{{7'b0, led_e[i]}, i == 7, 1'b0});
    end
    exp_q.push_back('{{4'b1000, on_e, bri_e}, 1'b1, 1'b1});
  endfunction

  // Serial monitor, TM1638 key model and scoreboard.
  always @(negedge clk_400KHz) begin
    if (!rst) begin
      exp_q.delete();
      kq.delete();
      pending = 1'b1;
      m_prev = 8'd0; m_cnt = 0; m_state = 8'd0;
      tb_drive = 1'b0;
      byte_in_txn = 0;
      cur_first = 8'h00;
      is_key = 1'b0;
    end else begin
      if (prev_stb && !STB) begin
        bit_cnt = 0; byte_in_txn = 0; rd_fall = 0; rd_rise = 0;
        is_key = 1'b0; cur_first = 8'h00;
        last_e = '{8'h00, 1'b0, 1'b0};
        if (pending) begin
          push_frame();
          pending = 1'b0;
        end
      end
      if (!STB && !tm_clk && prev_tclk && is_key && rd_fall < 32) begin
        tb_bit = key_bytes[rd_fall / 8][rd_fall % 8];
        drv_raw[rd_fall] = tb_bit;
        tb_drive = 1'b1;
        rd_fall++;
      end
      if (!STB && tm_clk && !prev_tclk) begin
        if (is_key) rd_rise++;
        else begin
          cur_byte[bit_cnt % 8] = DIO;
          bit_cnt++;
          if (bit_cnt % 8 == 0) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sb_byte unexpected byte got %02h expected none", cur_byte);
            end else begin
              last_e = exp_q.pop_front();
              if (cur_byte !== last_e.b) begin
                errors++;
                $display("FAIL sb_byte txn %02h idx %0d got %02h expected %02h",
                         cur_first, byte_in_txn, cur_byte, last_e.b);
              end
            end
            if (byte_in_txn == 0) begin
              cur_first = cur_byte;
              is_key = cur_byte == 8'h42;
              if (cur_byte[7:4] == 4'h8) last_ctrl = cur_byte;
            end else if (cur_first == 8'hC0 && byte_in_txn <= 16) begin
              addr_obs[byte_in_txn - 1] = cur_byte;
            end
            byte_in_txn++;
          end
        end
      end
      if (!prev_stb && STB) begin
        tb_drive = 1'b0;
        checks++;
        if (!((bit_cnt % 8 == 0) && last_e.last && (!is_key || rd_rise == 32))) begin
          errors++;
          $display("FAIL txn_end first %02h bits %0d reads %0d expected whole bytes, 32 reads on key txn",
                   cur_first, bit_cnt, rd_rise);
        end
        if (is_key) begin
          for (int b = 0; b < 4; b++) begin
            r8[2*b]   = drv_raw[8*b];
            r8[2*b+1] = drv_raw[8*b+4];
          end
          if (r8 == m_prev) m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
          else              m_cnt = 1;
          m_prev = r8;
          if (m_cnt == 3 && r8 != m_state) begin
            m_state = r8;
            kq.push_back(r8);
          end
          key_reads++;
        end
        if (last_e.eof) pending = 1'b1;
        cur_first = 8'h00;
        is_key = 1'b0;
      end
      if (key_change) begin
        kc_count++;
        checks++;
        if (kq.size() == 0) begin
          errors++;
          $display("FAIL key_change unexpected pulse key_state %02h expected no pulse", key_state);
        end else begin
          kexp = kq.pop_front();
          if (key_state !== kexp) begin
            errors++;
            $display("FAIL key_state got %02h expected %02h", key_state, kexp);
          end
        end
      end
    end
    prev_stb  = STB;
    prev_tclk = tm_clk;
  end

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk_400KHz);
      n++;
    end while (!frame_done && n < 2000);
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout got none expected pulse within 2000 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk_400KHz);
    checks++; if (STB !== 1'b1)        begin errors++; $display("FAIL reset_stb got %b expected 1", STB); end
    checks++; if (tm_clk !== 1'b1)     begin errors++; $display("FAIL reset_tm_clk got %b expected 1", tm_clk); end
    checks++; if (DIO !== 1'b1)        begin errors++; $display("FAIL reset_dio got %b expected 1", DIO); end
    checks++; if (key_state !== 8'd0)  begin errors++; $display("FAIL reset_key_state got %02h expected 00", key_state); end
    checks++; if (key_change !== 1'b0) begin errors++; $display("FAIL reset_key_change got %b expected 0", key_change); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b expected 0", frame_done); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    @(posedge clk_400KHz); #1;
    rst = 1'b1;
    enable = 1'b1;
  endtask

  task automatic test_frame_period();
    int n;
    wait_fd(n);
    for (int k = 0; k < 2; k++) begin
      wait_fd(n);
      checks++;
      if (n != 410) begin errors++; $display("FAIL frame_period got %0d expected 410", n); end
    end
    @(negedge clk_400KHz);
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b expected 0", frame_done); end
  endtask

  task automatic test_seg_led();
    int n;
    @(posedge clk_400KHz); #1;
    seg_data = 64'h0600_0000_0000_003F;
    led_data = 8'b1000_0001;
    wait_fd(n);
    wait_fd(n);
    checks++; if (addr_obs[0]  !== 8'h3F) begin errors++; $display("FAIL addr_byte0 got %02h expected 3F", addr_obs[0]); end
    checks++; if (addr_obs[1]  !== 8'h01) begin errors++; $display("FAIL addr_byte1 got %02h expected 01", addr_obs[1]); end
    checks++; if (addr_obs[7]  !== 8'h00) begin errors++; $display("FAIL addr_byte7 got %02h expected 00", addr_obs[7]); end
    checks++; if (addr_obs[14] !== 8'h06) begin errors++; $display("FAIL addr_byte14 got %02h expected 06", addr_obs[14]); end
    checks++; if (addr_obs[15] !== 8'h01) begin errors++; $display("FAIL addr_byte15 got %02h expected 01", addr_obs[15]); end
  endtask

  task automatic wait_key_read(output bit ok);
    int start, n;
    start = key_reads;
    n = 0;
    while (key_reads == start && n < 1000) begin
      @(negedge clk_400KHz);
      n++;
    end
    ok = key_reads != start;
  endtask

  task automatic test_debounce();
    int n;
    bit ok1, ok2;
    kc_count = 0;
    @(posedge clk_400KHz); #1;
    key_bytes[1] = 8'h10;
    repeat (4) wait_fd(n);
    checks++; if (key_state !== 8'h08) begin errors++; $display("FAIL debounce_state got %02h expected 08", key_state); end
    checks++; if (kc_count != 1)       begin errors++; $display("FAIL debounce_pulses got %0d expected 1", kc_count); end
    wait_key_read(ok1);
    @(posedge clk_400KHz); #1;
    key_bytes[1] = 8'h00;
    wait_key_read(ok2);
    @(posedge clk_400KHz); #1;
    key_bytes[1] = 8'h10;
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL key_read_timeout got %b%b expected 11", ok1, ok2); end
    repeat (4) wait_fd(n);
    checks++; if (key_state !== 8'h08) begin errors++; $display("FAIL glitch_state got %02h expected 08", key_state); end
    checks++; if (kc_count != 1)       begin errors++; $display("FAIL glitch_pulses got %0d expected 1", kc_count); end
  endtask

  task automatic wait_addr(input int k, output bit ok);
    int n;
    n = 0;
    while (!(cur_first == 8'hC0 && byte_in_txn >= k) && n < 1000) begin
      @(negedge clk_400KHz);
      n++;
    end
    ok = n < 1000;
  endtask

  task automatic test_brightness();
    int  n;
    bit  ok;
    wait_addr(3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL addr_wait_timeout got none expected ADDR_DATA"); end
    @(posedge clk_400KHz); #1;
    brightness = 3'd2;
    wait_fd(n);
    checks++; if (last_ctrl !== 8'h8F) begin errors++; $display("FAIL ctrl_current got %02h expected 8F", last_ctrl); end
    wait_fd(n);
    checks++; if (last_ctrl !== 8'h8A) begin errors++; $display("FAIL ctrl_next got %02h expected 8A", last_ctrl); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    wait_addr(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL addr_wait_timeout got none expected ADDR_DATA byte 5"); end
    @(posedge clk_400KHz); #2;
    rst = 1'b0;
    #1;
    checks++; if (STB !== 1'b1)    begin errors++; $display("FAIL midreset_stb got %b expected 1", STB); end
    checks++; if (tm_clk !== 1'b1) begin errors++; $display("FAIL midreset_tm_clk got %b expected 1", tm_clk); end
    checks++; if (DIO !== 1'b1)    begin errors++; $display("FAIL midreset_dio got %b expected 1", DIO); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL midreset_busy got %b expected 0", busy); end
    @(posedge clk_400KHz); #1;
    rst = 1'b1;
    n = 0;
    while (byte_in_txn < 1 && n < 200) begin
      @(negedge clk_400KHz);
      n++;
    end
    checks++;
    if (cur_first !== 8'h42) begin errors++; $display("FAIL restart_first got %02h expected 42", cur_first); end
  endtask

  task automatic test_drain();
    @(posedge clk_400KHz); #1;
    enable = 1'b0;
    repeat (600) @(negedge clk_400KHz);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL drain_busy got %b expected 0", busy); end
    checks++; if (STB !== 1'b1)       begin errors++; $display("FAIL drain_stb got %b expected 1", STB); end
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL drain_bytes got %0d left expected 0", exp_q.size()); end
    checks++; if (kq.size() != 0)     begin errors++; $display("FAIL drain_keys got %0d left expected 0", kq.size()); end
  endtask

  task automatic test_single_frame_small();
    int busy_cnt, fd_cnt;
    busy_cnt = 0;
    fd_cnt = 0;
    @(posedge clk_400KHz); #1;
    enable_s = 1'b1;
    @(posedge clk_400KHz); #1;
    enable_s = 1'b0;
    repeat (500) begin
      @(negedge clk_400KHz);
      if (busy_s) busy_cnt++;
      if (frame_done_s) fd_cnt++;
    end
    checks++; if (busy_cnt != 268) begin errors++; $display("FAIL small_frame_len got %0d expected 268", busy_cnt); end
    checks++; if (fd_cnt != 1)     begin errors++; $display("FAIL small_frame_done got %0d expected 1", fd_cnt); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL small_idle_busy got %b expected 0", busy_s); end
    checks++; if (stb_s !== 1'b1)  begin errors++; $display("FAIL small_idle_stb got %b expected 1", stb_s); end
  endtask

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    enable_s = 1'b0;
    seg_data = 64'd0;
    led_data = 8'd0;
    brightness = 3'd7;
    display_on = 1'b1;
    for (int i = 0; i < 4; i++) key_bytes[i] = 8'h00;
    test_reset();
    test_frame_period();
    test_seg_led();
    test_debounce();
    test_brightness();
    test_reset_mid();
    test_drain();
    test_single_frame_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
